mem_wb_stage: RTL and testbench



---
 rtl/rv_pkg.sv | 18 +
 rtl/load_align.sv | 52 +++++
 rtl/mem_wb_stage.sv | 96 +++++++++
 tb/tb_mem_wb_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V encodings used by the write-back path: write-source selects
// and load funct3 codes.
package rv_pkg;

  // Write-back source select carried down the pipe from decode
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_RSVD = 2'b11;

  // Load funct3 codes; 011, 110 and 111 are illegal for loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of the
// raw aligned memory word, extends it, and flags misaligned or illegal loads.
module load_align
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword lanes from the word
  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  // Extend per load type; halfword and word loads must be naturally aligned
  always_comb begin
    data  = 32'h0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'h0, byte_sel};
      F3_LH: begin
        data  = {{16{half_sel[15]}}, half_sel};
        fault = off[0];
      end
      F3_LHU: begin
        data  = {16'h0, half_sel};
        fault = off[0];
      end
      F3_LW: begin
        data  = word;
        fault = (off != 2'd0);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the write-back value, registers the
// REG_FILE write port, reports load faults and counts retired instructions.
module mem_wb_stage
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic                 mem_regwrite,
  input  logic [4:0]           mem_rd,
  input  logic [1:0]           mem_wb_sel,
  input  logic [2:0]           mem_funct3,
  input  logic [XLEN-1:0]      mem_alu_result,
  input  logic [XLEN-1:0]      mem_load_data,
  input  logic [XLEN-1:0]      mem_pc_plus4,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 regwrite,
  output logic [4:0]           write_reg,
  output logic [XLEN-1:0]      write_data,
  output logic                 wb_valid,
  output logic                 load_fault,
  output logic [INSTRET_W-1:0] instret
);

  logic [XLEN-1:0]      load_value;
  logic                 align_fault;

  logic                 wb_valid_q,   wb_valid_d;
  logic                 regwrite_q,   regwrite_d;
  logic                 load_fault_q, load_fault_d;
  logic [4:0]           write_reg_q,  write_reg_d;
  logic [XLEN-1:0]      write_data_q, write_data_d;
  logic [INSTRET_W-1:0] instret_q,    instret_d;

  load_align u_load_align (
    .funct3 (mem_funct3),
    .off    (mem_alu_result[1:0]),
    .word   (mem_load_data),
    .data   (load_value),
    .fault  (align_fault)
  );

  // Next WB contents: a bubble on flush/stall, otherwise capture the MEM instruction
  always_comb begin
    wb_valid_d   = 1'b0;
    regwrite_d   = 1'b0;
    load_fault_d = 1'b0;
    write_reg_d  = 5'd0;
    write_data_d = '0;
    if (!(flush || stall)) begin
      wb_valid_d   = mem_valid;
      write_reg_d  = mem_rd;
      load_fault_d = mem_valid && (mem_wb_sel == WB_LOAD) && align_fault;
      case (mem_wb_sel)
        WB_ALU:  write_data_d = mem_alu_result;
        WB_LOAD: write_data_d = load_value;
        WB_PC4:  write_data_d = mem_pc_plus4;
        default: write_data_d = '0;
      endcase
      regwrite_d = mem_valid && mem_regwrite && (mem_rd != 5'd0) &&
                   !load_fault_d && (mem_wb_sel != WB_RSVD);
    end
    instret_d = instret_q + INSTRET_W'(wb_valid_q && !load_fault_q);
  end

  // WB register bank with synchronous reset taking priority over everything
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      load_fault_q <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= '0;
      instret_q    <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      regwrite_q   <= regwrite_d;
      load_fault_q <= load_fault_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      instret_q    <= instret_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign regwrite   = regwrite_q;
  assign load_fault = load_fault_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed scenarios followed by random traffic,
// all compared against a behavioural model of the write-back rules.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_regwrite = 1'b0;
  logic [4:0]  mem_rd = 5'd0;
  logic [1:0]  mem_wb_sel = 2'b00;
  logic [2:0]  mem_funct3 = 3'b000;
  logic [31:0] mem_alu_result = 32'h0;
  logic [31:0] mem_load_data = 32'h0;
  logic [31:0] mem_pc_plus4 = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        wb_valid;
  logic        load_fault;
  logic [63:0] instret;

  int total = 0;
  int bad = 0;

  logic        expWbValid = 1'b0;
  logic        expRegwrite = 1'b0;
  logic        expLoadFault = 1'b0;
  logic [4:0]  expWriteReg = 5'd0;
  logic [31:0] expWriteData = 32'h0;
  logic [63:0] expInstret = 64'd0;
  logic        expInReset = 1'b1;

  mem_wb_stage #(.XLEN(32), .INSTRET_W(64)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_regwrite   (mem_regwrite),
    .mem_rd         (mem_rd),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_pc_plus4   (mem_pc_plus4),
    .stall          (stall),
    .flush          (flush),
    .regwrite       (regwrite),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .wb_valid       (wb_valid),
    .load_fault     (load_fault),
    .instret        (instret)
  );

  // Free-running clock
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Value a load instruction should deliver, and whether it must trap
  function automatic logic [31:0] loadValue(input logic [2:0] f3, input int off,
                                            input logic [31:0] word, output logic trap);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    trap = 1'b0;
    loadValue = 32'h0;
    case (f3)
      3'd0: loadValue = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd4: loadValue = b;
      3'd1: if (off % 2 != 0) trap = 1'b1; else loadValue = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd5: if (off % 2 != 0) trap = 1'b1; else loadValue = h;
      3'd2: if (off != 0) trap = 1'b1; else loadValue = word;
      default: trap = 1'b1;
    endcase
  endfunction

  // Advance the reference model by one clock using the currently driven inputs
  task automatic modelStep();
    logic trap;
    logic [31:0] val;
    if (reset) begin
      expWbValid = 0; expRegwrite = 0; expLoadFault = 0;
      expWriteReg = 0; expWriteData = 0; expInstret = 0; expInReset = 1;
      return;
    end
    expInReset = 0;
    if (expWbValid && !expLoadFault) expInstret = expInstret + 1;
    if (flush || stall) begin
      expWbValid = 0; expRegwrite = 0; expLoadFault = 0;
      return;
    end
    trap = 1'b0;
    val = 32'h0;
    if (mem_wb_sel == 2'b00) val = mem_alu_result;
    else if (mem_wb_sel == 2'b10) val = mem_pc_plus4;
    else if (mem_wb_sel == 2'b01) val = loadValue(mem_funct3, int'(mem_alu_result % 4), mem_load_data, trap);
    expWbValid   = mem_valid;
    expWriteReg  = mem_rd;
    expWriteData = val;
    expLoadFault = mem_valid && trap;
    expRegwrite  = mem_valid && mem_regwrite && (mem_rd != 0) && !trap && (mem_wb_sel != 2'b11);
  endtask

  task automatic compareAll();
    checkOutput("wb_valid", 64'(wb_valid), 64'(expWbValid));
    checkOutput("regwrite", 64'(regwrite), 64'(expRegwrite));
    checkOutput("load_fault", 64'(load_fault), 64'(expLoadFault));
    checkOutput("instret", instret, expInstret);
    if (expInReset || (expWbValid && !expLoadFault)) begin
      checkOutput("write_reg", 64'(write_reg), 64'(expWriteReg));
      checkOutput("write_data", 64'(write_data), 64'(expWriteData));
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic rw, input logic [4:0] rd,
                               input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                               input logic [31:0] word, input logic [31:0] pc4,
                               input logic stl, input logic fl);
    reset = rst; mem_valid = v; mem_regwrite = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_funct3 = f3; mem_alu_result = alu; mem_load_data = word; mem_pc_plus4 = pc4;
    stall = stl; flush = fl;
    modelStep();
    @(posedge clock);
    #1;
    compareAll();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
  endtask

  initial begin
    logic [63:0] snap;
    // Reset state
    applyStimulus(1, 1, 1, 5'd7, 2'b00, 3'b000, 32'hDEAD, 32'h0, 32'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
    checkOutput("reset_instret", instret, 64'd0);
    checkOutput("reset_wdata", 64'(write_data), 64'd0);

    // ALU write
    applyStimulus(0, 1, 1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 0);
    checkOutput("alu_regwrite", 64'(regwrite), 64'd1);
    checkOutput("alu_wreg", 64'(write_reg), 64'd5);
    checkOutput("alu_wdata", 64'(write_data), 64'h1234);
    checkOutput("alu_instret0", instret, 64'd0);
    idle();
    checkOutput("alu_instret1", instret, 64'd1);

    // Load extraction from 0x80FF_7F01
    applyStimulus(0, 1, 1, 5'd1, 2'b01, 3'b000, 32'h0000_2003, 32'h80FF_7F01, 32'h0, 0, 0);
    checkOutput("lb_off3", 64'(write_data), 64'hFFFF_FF80);
    applyStimulus(0, 1, 1, 5'd2, 2'b01, 3'b100, 32'h0000_2001, 32'h80FF_7F01, 32'h0, 0, 0);
    checkOutput("lbu_off1", 64'(write_data), 64'h0000_007F);
    applyStimulus(0, 1, 1, 5'd3, 2'b01, 3'b001, 32'h0000_2002, 32'h80FF_7F01, 32'h0, 0, 0);
    checkOutput("lh_off2", 64'(write_data), 64'hFFFF_80FF);
    applyStimulus(0, 1, 1, 5'd4, 2'b01, 3'b101, 32'h0000_2000, 32'h80FF_7F01, 32'h0, 0, 0);
    checkOutput("lhu_off0", 64'(write_data), 64'h0000_7F01);
    idle();

    // Misaligned LW faults for exactly one cycle and does not retire
    snap = instret;
    applyStimulus(0, 1, 1, 5'd6, 2'b01, 3'b010, 32'h0000_1002, 32'h1111_2222, 32'h0, 0, 0);
    checkOutput("lw_fault", 64'(load_fault), 64'd1);
    checkOutput("lw_nowrite", 64'(regwrite), 64'd0);
    idle();
    checkOutput("lw_fault_pulse", 64'(load_fault), 64'd0);
    checkOutput("lw_instret", instret, snap);

    // JAL to x0 retires without writing
    applyStimulus(0, 1, 1, 5'd0, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0000_0104, 0, 0);
    checkOutput("jal_valid", 64'(wb_valid), 64'd1);
    checkOutput("jal_nowrite", 64'(regwrite), 64'd0);
    checkOutput("jal_wdata", 64'(write_data), 64'h104);
    idle();
    checkOutput("jal_instret", instret, snap + 1);

    // Stall then flush produce bubbles, then a normal capture
    applyStimulus(0, 1, 1, 5'd9, 2'b00, 3'b000, 32'hCAFE_0001, 32'h0, 32'h0, 1, 0);
    checkOutput("stall_bubble", 64'(wb_valid), 64'd0);
    applyStimulus(0, 1, 1, 5'd9, 2'b00, 3'b000, 32'hCAFE_0001, 32'h0, 32'h0, 0, 1);
    checkOutput("flush_bubble", 64'(regwrite), 64'd0);
    applyStimulus(0, 1, 1, 5'd9, 2'b00, 3'b000, 32'hCAFE_0001, 32'h0, 32'h0, 0, 0);
    checkOutput("after_bubble", 64'(write_data), 64'hCAFE_0001);

    // Reset while a valid load sits in WB
    applyStimulus(0, 1, 1, 5'd12, 2'b01, 3'b010, 32'h0000_3000, 32'h5555_AAAA, 32'h0, 0, 0);
    applyStimulus(1, 1, 1, 5'd13, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 0, 0);
    checkOutput("rst_mid_regwrite", 64'(regwrite), 64'd0);
    checkOutput("rst_mid_instret", instret, 64'd0);
    applyStimulus(0, 1, 1, 5'd13, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 0, 0);
    checkOutput("rst_first_capture", 64'(write_data), 64'h77);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] sel;
      sel = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                    sel, 3'($urandom), $urandom, $urandom, $urandom,
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
